// File: rtl/gate_vector_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : gate_vector_sequencer_if
// Purpose : Bundles the control/status and gate-stimulus signals of
//           gate_vector_sequencer.
// Ports   : start, res_a, res_b             -> into the sequencer
//           vec, busy, done, mismatch_cnt,
//           fail, first_fail_idx,
//           first_fail_vld                  <- from the sequencer
//           master = sequencer side, slave = environment side
// Revision: 1.0  initial release
// ============================================================================
interface gate_vector_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic [N_IN-1:0] vec;
  logic            res_a;
  logic            res_b;
  logic            busy;
  logic            done;
  logic [N_IN:0]   mismatch_cnt;
  logic            fail;
  logic [N_IN-1:0] first_fail_idx;
  logic            first_fail_vld;

  modport master (
    input  start, res_a, res_b,
    output vec, busy, done, mismatch_cnt, fail, first_fail_idx, first_fail_vld
  );

  modport slave (
    output start, res_a, res_b,
    input  vec, busy, done, mismatch_cnt, fail, first_fail_idx, first_fail_vld
  );
endinterface
`default_nettype wire

// File: rtl/gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : gate_vector_sequencer
// Purpose : Walks vec through every truth-table row of an N_IN-input gate,
//           holds each row SETTLE cycles, then samples two implementations
//           (res_a, res_b) and counts rows where they disagree. Reports the
//           mismatch count, a fail flag and the first failing row.
// Ports   : clk    - rising-edge clock
//           rst_n  - asynchronous reset, active low
//           bus    - gate_vector_sequencer_if.master (start, vec, res_a/b,
//                    busy, done, mismatch_cnt, fail, first_fail_idx/vld)
// Options : SEQ_GOLDEN_CHECK_EN - when defined, res_a is additionally
//           compared with GOLDEN[vec] so that two identically wrong
//           implementations are still flagged. Port list is the same.
// Revision: 1.0  initial release
// ============================================================================
module gate_vector_sequencer #(
  parameter int                     N_IN   = 2,
  parameter int                     SETTLE = 1,
  parameter logic [(1<<N_IN)-1:0]   GOLDEN = 4'b1101
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  gate_vector_sequencer_if.master bus
);

  localparam int              CW   = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [N_IN-1:0] r_vec;
  logic            r_busy;
  logic            r_done;
  logic [N_IN:0]   r_mismatch_cnt;
  logic            r_fail;
  logic [N_IN-1:0] r_first_fail_idx;
  logic            r_first_fail_vld;
  logic            w_row_err;

`ifdef SEQ_GOLDEN_CHECK_EN
  assign w_row_err = (bus.res_a != bus.res_b) | (bus.res_a != GOLDEN[r_vec]);
`else
  // Only the cross-check between the two implementations is used here.
  logic w_unused_golden;
  assign w_unused_golden = ^GOLDEN;
  assign w_row_err       = (bus.res_a != bus.res_b);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      r_vec            <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_mismatch_cnt   <= '0;
      r_fail           <= 1'b0;
      r_first_fail_idx <= '0;
      r_first_fail_vld <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state          <= WAIT;
            r_cnt            <= CW'(SETTLE);
            r_vec            <= '0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_mismatch_cnt   <= '0;
            r_fail           <= 1'b0;
            r_first_fail_idx <= '0;
            r_first_fail_vld <= 1'b0;
          end
        end
        WAIT: begin
          // Leaving at cnt==1 makes WAIT last exactly SETTLE cycles.
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          if (w_row_err) begin
            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
            r_fail         <= 1'b1;
            if (!r_first_fail_vld) begin
              r_first_fail_idx <= r_vec;
              r_first_fail_vld <= 1'b1;
            end
          end
          // vec stays on the last row so DONE reports where the sweep ended.
          if (r_vec == LAST) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_vec   <= r_vec + 1'b1;
            r_cnt   <= CW'(SETTLE);
            r_state <= WAIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec            = r_vec;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.mismatch_cnt   = r_mismatch_cnt;
  assign bus.fail           = r_fail;
  assign bus.first_fail_idx = r_first_fail_idx;
  assign bus.first_fail_vld = r_first_fail_vld;

endmodule
`default_nettype wire

// File: tb/tb_gate_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_gate_vector_sequencer
// Purpose : Directed self-checking bench for gate_vector_sequencer. Drives
//           res_a/res_b from a small gate model of a|~b (vec = {a,b}) with
//           selectable defects; instance dut0 uses SETTLE=1, dut1 SETTLE=3.
//           Edge numbering: edge 1 is the edge that samples start.
// Options : SEQ_GOLDEN_CHECK_EN selects the expected result of the
//           identical-defect sweep.
// Revision: 1.0  initial release
// ============================================================================
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gate_vector_sequencer_if #(.N_IN(2)) bus0 ();
  gate_vector_sequencer_if #(.N_IN(2)) bus1 ();

  gate_vector_sequencer #(.N_IN(2), .SETTLE(1), .GOLDEN(4'b1101)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  gate_vector_sequencer #(.N_IN(2), .SETTLE(3), .GOLDEN(4'b1101)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // mode 0: both correct; 1: res_b wrong at vec=01 only;
  // 2: both implementations share the same defect at vec=01.
  int mode0 = 0;
  int mode1 = 0;

  function automatic logic res_model(input logic [1:0] v, input int m, input bit is_b);
    logic good;
    good = v[1] | ~v[0];
    if (v == 2'b01 && ((m == 1 && is_b) || m == 2)) return ~good;
    return good;
  endfunction

  assign bus0.res_a = res_model(bus0.vec, mode0, 1'b0);
  assign bus0.res_b = res_model(bus0.vec, mode0, 1'b1);
  assign bus1.res_a = res_model(bus1.vec, mode1, 1'b0);
  assign bus1.res_b = res_model(bus1.vec, mode1, 1'b1);

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full sweep on dut0 starting at a negedge. repulse_edge > 0 raises start
  // again after that edge (while busy) for one cycle.
  task automatic sweep0(input string name, input int repulse_edge,
                        input logic [2:0] exp_cnt, input logic exp_fail,
                        input logic [1:0] exp_idx, input logic exp_vld);
    bus0.start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus0.start = (k == repulse_edge);
      if (k == 1) begin
        check_val($sformatf("%s cnt_clr", name), 32'(bus0.mismatch_cnt), 32'd0);
        check_val($sformatf("%s vld_clr", name), 32'(bus0.first_fail_vld), 32'd0);
      end
      if (k <= 8) begin
        check_val($sformatf("%s vec@%0d", name, k), 32'(bus0.vec), 32'((k - 1) / 2));
        check_val($sformatf("%s busy@%0d", name, k), 32'(bus0.busy), 32'd1);
        check_val($sformatf("%s done@%0d", name, k), 32'(bus0.done), 32'd0);
      end else begin
        check_val($sformatf("%s vec@%0d", name, k), 32'(bus0.vec), 32'd3);
        check_val($sformatf("%s busy@%0d", name, k), 32'(bus0.busy), 32'd0);
        check_val($sformatf("%s done@%0d", name, k), 32'(bus0.done), 32'd1);
      end
    end
    check_val($sformatf("%s mismatch_cnt", name), 32'(bus0.mismatch_cnt), 32'(exp_cnt));
    check_val($sformatf("%s fail", name), 32'(bus0.fail), 32'(exp_fail));
    check_val($sformatf("%s first_fail_vld", name), 32'(bus0.first_fail_vld), 32'(exp_vld));
    if (exp_vld)
      check_val($sformatf("%s first_fail_idx", name), 32'(bus0.first_fail_idx), 32'(exp_idx));
  endtask

  task automatic check_zero0(input string name);
    check_val($sformatf("%s vec", name), 32'(bus0.vec), 32'd0);
    check_val($sformatf("%s busy", name), 32'(bus0.busy), 32'd0);
    check_val($sformatf("%s done", name), 32'(bus0.done), 32'd0);
    check_val($sformatf("%s mismatch_cnt", name), 32'(bus0.mismatch_cnt), 32'd0);
    check_val($sformatf("%s fail", name), 32'(bus0.fail), 32'd0);
    check_val($sformatf("%s first_fail_idx", name), 32'(bus0.first_fail_idx), 32'd0);
    check_val($sformatf("%s first_fail_vld", name), 32'(bus0.first_fail_vld), 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    repeat (2) @(negedge clk);
    check_zero0("reset");
    check_val("reset dut1 done", 32'(bus1.done), 32'd0);
    check_val("reset dut1 busy", 32'(bus1.busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Correct pair: clean sweep, done at edge 9.
    mode0 = 0;
    sweep0("clean", 0, 3'd0, 1'b0, 2'b00, 1'b0);

    // res_b wrong at 01 only; sweep launched straight from DONE.
    mode0 = 1;
    sweep0("b_wrong", 0, 3'd1, 1'b1, 2'b01, 1'b1);

    // Restart from DONE after a failing sweep clears the results.
    mode0 = 0;
    sweep0("restart", 0, 3'd0, 1'b0, 2'b00, 1'b0);

    // Both wrong identically at 01: only the golden check can see it.
    mode0 = 2;
`ifdef SEQ_GOLDEN_CHECK_EN
    sweep0("same_wrong", 0, 3'd1, 1'b1, 2'b01, 1'b1);
`else
    sweep0("same_wrong", 0, 3'd0, 1'b0, 2'b00, 1'b0);
`endif

    // start pulsed while busy must not disturb the timing.
    mode0 = 1;
    sweep0("busy_start", 3, 3'd1, 1'b1, 2'b01, 1'b1);

    // Asynchronous reset right after edge 4 of a sweep.
    mode0 = 0;
    bus0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero0("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sweep0("after_rst", 0, 3'd0, 1'b0, 2'b00, 1'b0);

    // SETTLE=3: each row held 4 cycles, done at edge 17.
    mode1 = 1;
    bus1.start = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus1.start = 1'b0;
      if (k <= 16) begin
        check_val($sformatf("settle3 vec@%0d", k), 32'(bus1.vec), 32'((k - 1) / 4));
        check_val($sformatf("settle3 done@%0d", k), 32'(bus1.done), 32'd0);
      end else begin
        check_val($sformatf("settle3 done@%0d", k), 32'(bus1.done), 32'd1);
        check_val($sformatf("settle3 busy@%0d", k), 32'(bus1.busy), 32'd0);
      end
    end
    check_val("settle3 mismatch_cnt", 32'(bus1.mismatch_cnt), 32'd1);
    check_val("settle3 first_fail_idx", 32'(bus1.first_fail_idx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
